// File: rtl/pixel_window_buffer.sv
// 3x3 RGB565 neighbourhood builder: three rotating line RAMs plus per-row
// column shift registers, emitting one registered window per accepted pixel.

module pwb_line_ram #(
    parameter int DEPTH = 320,
    parameter int AW    = 9
) (
    input  logic          clk_in,
    input  logic          we_in,
    input  logic          re_in,
    input  logic [AW-1:0] addr_in,
    input  logic [15:0]   wdata_in,
    output logic [15:0]   rdata_out
);
    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_in) begin
        if (we_in) mem_q[addr_in] <= wdata_in;
        if (re_in) rdata_q <= mem_q[addr_in];
    end

    assign rdata_out = rdata_q;
endmodule

module pixel_window_buffer #(
    parameter int HRES = 320,
    parameter int VRES = 180
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic [15:0]           pixel_in,
    output logic                  valid_out,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic [2:0][2:0][15:0] window_out
);
    localparam int          AW    = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [10:0] HLIM  = 11'(HRES);
    localparam logic [10:0] HLAST = 11'(HRES - 1);
    localparam logic [9:0]  VLIM  = 10'(VRES);

    function automatic logic [1:0] inc3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] s);
        return (s == 2'd0) ? 2'd2 : s - 2'd1;
    endfunction

    function automatic logic [15:0] pick(input logic [2:0][15:0] d, input logic [1:0] s);
        case (s)
            2'd1:    return d[1];
            2'd2:    return d[2];
            default: return d[0];
        endcase
    endfunction

    // ---------------- stage 0: accept, RAM select, write/read issue
    logic              accept;
    logic [1:0]        line_q, line_d;
    logic [1:0]        wsel, rsel_top, rsel_mid;
    logic [AW-1:0]     addr;
    logic [2:0][15:0]  ram_rd;

    assign accept   = valid_in && (hcount_in < HLIM) && (vcount_in < VLIM);
    assign wsel     = (vcount_in == '0) ? 2'd0 : line_q;
    assign rsel_mid = dec3(wsel);
    // line v-2 lives in (v-2) mod 3, which equals (v+1) mod 3
    assign rsel_top = inc3(wsel);
    assign addr     = hcount_in[AW-1:0];

    always_comb begin
        line_d = line_q;
        if (accept) line_d = (hcount_in == HLAST) ? inc3(wsel) : wsel;
    end

    for (genvar k = 0; k < 3; k++) begin : g_ram
        pwb_line_ram #(.DEPTH(HRES), .AW(AW)) u_ram (
            .clk_in   (clk_in),
            .we_in    (accept && (wsel == 2'(k))),
            .re_in    (accept && (wsel != 2'(k))),
            .addr_in  (addr),
            .wdata_in (pixel_in),
            .rdata_out(ram_rd[k])
        );
    end

    // ---------------- stage 1: pixel delay aligned with RAM read data
    logic        s1_vld_q;
    logic [15:0] pix1_q;
    logic [10:0] h1_q;
    logic [9:0]  v1_q;
    logic [1:0]  rsel_top_q, rsel_mid_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_q     <= 2'd0;
            s1_vld_q   <= 1'b0;
            pix1_q     <= '0;
            h1_q       <= '0;
            v1_q       <= '0;
            rsel_top_q <= 2'd0;
            rsel_mid_q <= 2'd0;
        end else begin
            line_q   <= line_d;
            s1_vld_q <= accept;
            if (accept) begin
                pix1_q     <= pixel_in;
                h1_q       <= hcount_in;
                v1_q       <= vcount_in;
                rsel_top_q <= rsel_top;
                rsel_mid_q <= rsel_mid;
            end
        end
    end

    // ---------------- stage 2: column shift, zero-fill, output register
    logic [2:0][15:0]      samp;
    logic [2:0][2:0][15:0] col_q, col_d;
    logic [2:0][2:0][15:0] win_q, win_d;
    logic                  vld_out_q;
    logic [10:0]           hout_q;
    logic [9:0]            vout_q;

    assign samp[0] = pick(ram_rd, rsel_top_q);
    assign samp[1] = pick(ram_rd, rsel_mid_q);
    assign samp[2] = pix1_q;

    always_comb begin
        col_d = col_q;
        win_d = win_q;
        if (s1_vld_q) begin
            for (int r = 0; r < 3; r++)
                col_d[r] = {samp[r], col_q[r][2], col_q[r][1]};
            win_d = col_d;
            // masking depends only on the anchor, so the shift registers keep raw data
            for (int r = 0; r < 3; r++) begin
                if (h1_q < 11'd2) win_d[r][0] = '0;
                if (h1_q < 11'd1) win_d[r][1] = '0;
            end
            if (v1_q < 10'd2) win_d[0] = '0;
            if (v1_q < 10'd1) win_d[1] = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col_q     <= '0;
            win_q     <= '0;
            vld_out_q <= 1'b0;
            hout_q    <= '0;
            vout_q    <= '0;
        end else begin
            col_q     <= col_d;
            win_q     <= win_d;
            vld_out_q <= s1_vld_q;
            if (s1_vld_q) begin
                hout_q <= h1_q;
                vout_q <= v1_q;
            end
        end
    end

    assign valid_out  = vld_out_q;
    assign hcount_out = hout_q;
    assign vcount_out = vout_q;
    assign window_out = win_q;
endmodule

// File: tb/tb_pixel_window_buffer.sv
// Scoreboard bench for pixel_window_buffer on a small 8x6 frame.

module tb_pixel_window_buffer;
    localparam int HR = 8;
    localparam int VR = 6;

    typedef logic [2:0][2:0][15:0] win_t;
    typedef struct {
        int   h;
        int   v;
        int   stamp;
        win_t win;
        bit   cw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in, valid_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        valid_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    win_t        window_out;

    always #5 clk = ~clk;

    pixel_window_buffer #(.HRES(HR), .VRES(VR)) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .pixel_in  (pixel_in),
        .valid_out (valid_out),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .window_out(window_out)
    );

    exp_t        q[$];
    logic [15:0] frame [VR][HR];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          win_en = 1'b1;
    bit          dir_ramp = 1'b0;
    bit          dir_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic win_t model(input int h, input int v);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int hh = h - 2 + j;
                int vv = v - 2 + i;
                w[i][j] = (hh < 0 || vv < 0) ? 16'h0 : frame[vv][hh];
            end
        return w;
    endfunction

    task automatic beat(input int h, input int v, input logic [15:0] p, input bit rst = 1'b0);
        exp_t e;
        valid_in  = 1'b1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_in  = p;
        rst_in    = rst;
        if (rst) begin
            // beats that would emerge after the reset edge are lost
            while (q.size() > 0 && q[$].stamp >= cyc - 1) void'(q.pop_back());
        end else if (h < HR && v < VR) begin
            frame[v][h] = p;
            e.h = h; e.v = v; e.stamp = cyc; e.win = model(h, v); e.cw = win_en;
            q.push_back(e);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst_in   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic stream(input int v0, input int v1, input int duty);
        for (int v = v0; v <= v1; v++)
            for (int h = 0; h < HR; h++) begin
                while (duty < 100 && $urandom_range(0, 99) >= duty) idle(1);
                beat(h, v, {8'(v), 8'(h)});
            end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, valid_out, 0);
        check_eq({tag, "_hcount"}, hcount_out, 0);
        check_eq({tag, "_vcount"}, vcount_out, 0);
        check_eq({tag, "_window"}, window_out, 0);
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) check_eq("spurious_valid", valid_out, 0);
            else begin
                exp_t e;
                win_t dw;
                e = q.pop_front();
                check_eq("latency", cyc, e.stamp + 2);
                check_eq("hcount", hcount_out, e.h);
                check_eq("vcount", vcount_out, e.v);
                if (e.cw) check_eq("window", window_out, e.win);
                if (dir_ramp && e.h == 5 && e.v == 3) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) dw[i][j] = {8'(1 + i), 8'(3 + j)};
                    check_eq("ramp_5_3", window_out, dw);
                end
                if (dir_start && e.h == 0 && e.v == 0) begin
                    dw = '0;
                    dw[2][2] = 16'hABCD;
                    check_eq("frame_start", window_out, dw);
                end
            end
        end else if (q.size() > 0 && cyc >= q[0].stamp + 2) begin
            check_eq("missing_valid", valid_out, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1; valid_in = 1'b0;
        hcount_in = '0; vcount_in = '0; pixel_in = '0;
        idle(3);
        rst_in = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;

        // lone first pixel of a frame
        dir_start = 1'b1;
        beat(0, 0, 16'hABCD);
        idle(4);
        dir_start = 1'b0;

        // continuous ramp, with out-of-range beats that must be ignored
        dir_ramp = 1'b1;
        stream(0, 2, 100);
        beat(7, VR, 16'hFFFF);
        beat(HR, 2, 16'hEEEE);
        stream(3, VR - 1, 100);
        idle(4);
        dir_ramp = 1'b0;

        // same ramp at ~40% duty; leaves the line counter mid-rotation
        stream(0, 3, 40);
        idle(4);

        // new frame (forced RAM index 0), then reset mid line 2 with a beat present
        stream(0, 1, 100);
        for (int h = 0; h < 4; h++) beat(h, 2, {8'd2, 8'(h)});
        beat(4, 2, 16'h1234, 1'b1);
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        idle(3);
        win_en = 1'b0;
        stream(2, 3, 100);
        win_en = 1'b1;
        stream(4, VR - 1, 100);
        idle(5);
        check_eq("queue_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
